// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART link constants and bit-FSM state encoding.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int unsigned DIV_DEFAULT  = 434;
    localparam int unsigned TOUT_DEFAULT = 20;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] WAITHI = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 byte receiver: 2-FF line synchronizer plus bit-level FSM.
// Revision : 1.0
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       bvld_o,
    output logic       ferr_o,
    output logic       busy_o,
    output logic       sof_o
);

    localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic          sync_q;
    logic          rxs_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bcnt_q,  bcnt_d;
    logic [7:0]    sh_q,    sh_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        bvld_o  = 1'b0;
        ferr_o  = 1'b0;
        sof_o   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                    bcnt_d  = '0;
                    sof_o   = 1'b1;
                end
            end
            START: begin
                // Mid-start-bit sample; a high line here was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    sh_d   = {rxs_q, sh_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        bvld_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_o  = 1'b1;
                        state_d = WAITHI;
                    end
                end
            end
            WAITHI: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= rx_i;
            rxs_q   <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
        end
    end

    assign byte_o = sh_q;
    assign busy_o = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word
// Brief    : Assembles two received UART bytes (high first) into 16-bit words.
// Revision : 1.0
// ============================================================================
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned DIV  = DIV_DEFAULT,
    parameter int unsigned TOUT = TOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic [15:0] word_o,
    output logic        rdy_o,
    output logic        ferr_o,
    output logic        tout_o,
    output logic        busy_o
);

    localparam int unsigned   LIM    = DIV * TOUT;
    localparam int unsigned   TW     = $clog2(LIM + 1);
    localparam logic [TW-1:0] LIM_M1 = TW'(LIM - 1);

    logic [7:0]    w_byte;
    logic          w_bvld;
    logic          w_ferr;
    logic          w_busy;
    logic          w_sof;

    logic          sel_q,  sel_d;
    logic [7:0]    hi_q,   hi_d;
    logic [15:0]   word_q, word_d;
    logic          rdy_q,  rdy_d;
    logic          ferr_q, ferr_d;
    logic          tout_q, tout_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    uart_rx_byte #(
        .DIV    (DIV)
    ) u_byte (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (rx_i),
        .byte_o (w_byte),
        .bvld_o (w_bvld),
        .ferr_o (w_ferr),
        .busy_o (w_busy),
        .sof_o  (w_sof)
    );

    always_comb begin
        sel_d  = sel_q;
        hi_d   = hi_q;
        word_d = word_q;
        rdy_d  = 1'b0;
        ferr_d = w_ferr;
        tout_d = 1'b0;
        tcnt_d = tcnt_q;

        if (w_ferr) begin
            sel_d = 1'b0;
        end else if (w_bvld) begin
            if (!sel_q) begin
                hi_d  = w_byte;
                sel_d = 1'b1;
            end else begin
                word_d = {hi_q, w_byte};
                rdy_d  = 1'b1;
                sel_d  = 1'b0;
            end
        end

        // A start detect wins over a same-cycle expiry and restarts the wait.
        if (w_busy || w_sof) begin
            tcnt_d = '0;
        end else if (sel_q) begin
            if (tcnt_q == LIM_M1) begin
                tout_d = 1'b1;
                sel_d  = 1'b0;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sel_q  <= 1'b0;
            hi_q   <= '0;
            word_q <= '0;
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            tout_q <= 1'b0;
            tcnt_q <= '0;
        end else begin
            sel_q  <= sel_d;
            hi_q   <= hi_d;
            word_q <= word_d;
            rdy_q  <= rdy_d;
            ferr_q <= ferr_d;
            tout_q <= tout_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign word_o = word_q;
    assign rdy_o  = rdy_q;
    assign ferr_o = ferr_q;
    assign tout_o = tout_q;
    assign busy_o = w_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx_word.md
# uart_rx_word

Host-to-FPGA receive path for the ADC/UART data link. It deserializes 8N1 UART bytes from the host line and assembles two consecutive bytes, MSB byte first, into one 16-bit word. It presents the word with a one-cycle strobe to downstream command or DAC logic. It is the receiving counterpart of the ADC-sample transmit sequencer, which sends each 16-bit conversion as two bytes, high byte first.

## Interface
- `DIV`, 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `TOUT`, 20: inter-byte timeout in bit periods, counted from the stop-bit sample of byte 0.
- `clk_i` in 1: single system clock.
- `rst_i` in 1: reset, synchronous and active-low.
- `rx_i` in 1: asynchronous UART line, idle high.
- `word_o` out 16: last assembled word, {byte0, byte1}. Holds until the next word completes.
- `rdy_o` out 1: one-cycle strobe, `word_o` valid.
- `ferr_o` out 1: one-cycle strobe on a framing error.
- `tout_o` out 1: one-cycle strobe when a half word is dropped by the inter-byte timeout.
- `busy_o` out 1: high while a byte is being received (states other than IDLE).

## Operation
- **Input synchronizer:** `rx_i` passes through 2 flip-flops. Both reset to 1. All logic uses the synchronized line `rxs`.
- **Bit FSM states:** IDLE, START, DATA, STOP, WAITHI.
  - **IDLE:** on `rxs`=0, go to START and clear the bit counter `bcnt`.
  - **START:** after DIV/2 (integer) cycles, sample `rxs`.
    - Sample 0: go to DATA.
    - Sample 1: glitch; return to IDLE with no strobe.
  - **DATA:** sample every DIV cycles. 8 samples are shifted in LSB first (right shift into bit 7). After the 8th sample, go to STOP.
  - **STOP:** sample after DIV cycles.
    - Sample 1: byte accepted; go to IDLE.
    - Sample 0: pulse `ferr_o`, discard the byte, clear `sel` to 0, go to WAITHI.
  - **WAITHI:** stay until `rxs`=1, then go to IDLE. This prevents a stuck-low line from retriggering.
- **Assembler:**
  - `sel`=0: an accepted byte goes to the high register. Set `sel`=1 and start the timeout counter.
  - `sel`=1: an accepted byte completes the word. Load `word_o` = {hi, byte}, pulse `rdy_o`, clear `sel`.
- **Timeout:**
  - Runs only while `sel`=1 and the FSM is in IDLE.
  - Counts DIV×TOUT cycles. On expiry, pulse `tout_o`, clear `sel`, and drop the high byte.
  - Entering START stops and clears the counter.
- **Simultaneous events:** timeout expiry in the same cycle as a start detect is resolved as a start. The counter is not expired and `sel` stays 1.
- **Reset:** asserted mid-byte, it aborts the byte. Everything returns to reset values.
- **Reset values:** state IDLE, `sel`=0, all counters 0, `word_o`=16'h0000, `rdy_o`=`ferr_o`=`tout_o`=`busy_o`=0.

## Timing
- The start edge is recognized 2 cycles after `rx_i` falls (synchronizer).
- Sample points relative to the first IDLE cycle with `rxs`=0:
  - Start sample at DIV/2.
  - Data bit k (0..7) at DIV/2 + (k+1)·DIV.
  - Stop sample at DIV/2 + 9·DIV.
- `rdy_o` and `ferr_o` are registered. Each is high in the cycle after the stop sample, for exactly 1 cycle.
- `word_o` updates in the same cycle `rdy_o` rises.
- IDLE is entered the cycle after the stop sample, so the next start bit may follow the stop bit back-to-back.
- **Counter widths:** the divider counter is ceil(log2(DIV)) bits and the timeout counter is ceil(log2(DIV·TOUT+1)) bits.

## Structure
- **Shared package `uart_pkg`:**
  - bit-FSM state encoding (3-bit localparams IDLE=0, START=1, DATA=2, STOP=3, WAITHI=4);
  - default `DIV` / `TOUT` constants, shared with the transmit side.
- **Sub-module `uart_rx_byte`:** synchronizer plus bit FSM. Outputs `byte_o[7:0]`, `bvld_o`, `ferr_o`, `busy_o`.
- **Top-level `uart_rx_word`:** assembler, timeout counter and output registers.

## Test plan
All scenarios run with `DIV`=8 and `TOUT`=4 for simulation.
1. **Reset:** drive `rx_i`=1 and hold `rst_i`=0 for 3 cycles → all outputs 0, `word_o`=0000. Then release.
2. **Nominal word:** send bytes 0xA5 then 0x3C back-to-back → exactly one `rdy_o` pulse, `word_o`=16'hA53C, `ferr_o`=`tout_o`=0.
3. **Framing error:** send 0x12 with stop bit 0, hold the line low 20 cycles, then send 0x34 and 0x56 → `ferr_o` pulses once, then `word_o`=16'h3456 with one `rdy_o`.
4. **Timeout:** send 0x77, idle 40 cycles (> 32), then send 0x88 and 0x99 → `tout_o` pulses once, then `word_o`=16'h8899.
5. **Start glitch:** `rx_i` low for 2 cycles then high → no strobes, `busy_o` returns to 0 within DIV/2 + 3 cycles, and the next word 0x0102 is received correctly.
6. **Reset mid-byte:** assert `rst_i`=0 during data bit 4 of byte 0 → outputs reset. After release, send 0xFF and 0x00 → `word_o`=16'hFF00.
